// File: rtl/address_generator_if.sv
// ---------------------------------------------------------------------------
// address_generator_if
// Control and address bus between the convolution controller and the
// address generator.
//   ldAdr   : controller -> generator, reload all pointers
//   rstX    : controller -> generator, start the next IFM window
//   sel     : controller -> generator, source select (x / y / z / hold)
//   reMem   : controller -> generator, memory read this cycle
//   weMem   : controller -> generator, memory write this cycle
//   adr     : generator -> memory,     shared memory address
//   winDone : generator -> controller, current window fully read
//   doneAdr : generator -> controller, last window fully read
// Modports: master = controller side, slave = address generator side.
// ---------------------------------------------------------------------------
interface address_generator_if #(
    parameter int ADDR_W = 16
) ();
    logic              ldAdr;
    logic              rstX;
    logic [1:0]        sel;
    logic              reMem;
    logic              weMem;
    logic [ADDR_W-1:0] adr;
    logic              winDone;
    logic              doneAdr;

    modport master (
        output ldAdr, rstX, sel, reMem, weMem,
        input  adr, winDone, doneAdr
    );

    modport slave (
        input  ldAdr, rstX, sel, reMem, weMem,
        output adr, winDone, doneAdr
    );
endinterface

// File: rtl/address_generator.sv
// ---------------------------------------------------------------------------
// address_generator
// Address generator for the convolution datapath. Keeps three independent
// pointers: the IFM window pointer (x), the filter pointer (y) and the OFM
// pointer (z), and drives the shared memory address from the selected one.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rstN   : asynchronous active-low reset
//   bus_io : address_generator_if.slave (ldAdr, rstX, sel, reMem, weMem in;
//            adr, winDone, doneAdr out)
// The address is combinational from state and sel so the memory can sample
// it in the same cycle as reMem/weMem. IFM row offsets are accumulated with
// adders instead of being multiplied out.
// ---------------------------------------------------------------------------
module address_generator #(
    parameter int ADDR_W    = 16,
    parameter int IFM_BASE  = 0,
    parameter int FILT_BASE = 64,
    parameter int OFM_BASE  = 128,
    parameter int IFM_W     = 8,
    parameter int IFM_H     = 8,
    parameter int K         = 3,
    parameter int N         = 2
) (
    input  logic                 clk,
    input  logic                 rstN,
    address_generator_if.slave   bus_io
);

    localparam int KK   = K * K;
    localparam int NKK  = N * KK;
    localparam int IJ_W = (K > 1) ? $clog2(K) : 1;
    localparam int XC_W = $clog2(KK + 1);
    localparam int FC_W = $clog2(NKK + 1);

    localparam logic [1:0] SEL_X    = 2'b00;
    localparam logic [1:0] SEL_Y    = 2'b01;
    localparam logic [1:0] SEL_Z    = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    localparam logic [ADDR_W-1:0] IFM_BASE_A  = ADDR_W'(IFM_BASE);
    localparam logic [ADDR_W-1:0] FILT_BASE_A = ADDR_W'(FILT_BASE);
    localparam logic [ADDR_W-1:0] OFM_BASE_A  = ADDR_W'(OFM_BASE);
    localparam logic [ADDR_W-1:0] ROW_STEP_A  = ADDR_W'(IFM_W);
    localparam logic [ADDR_W-1:0] C0_LAST     = ADDR_W'(IFM_W - K);
    localparam logic [ADDR_W-1:0] R0_LAST     = ADDR_W'(IFM_H - K);
    localparam logic [ADDR_W-1:0] ADDR_ZERO   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
    localparam logic [IJ_W-1:0]   IJ_ZERO     = IJ_W'(0);
    localparam logic [IJ_W-1:0]   IJ_ONE      = IJ_W'(1);
    localparam logic [IJ_W-1:0]   IJ_LAST     = IJ_W'(K - 1);
    localparam logic [XC_W-1:0]   XC_ZERO     = XC_W'(0);
    localparam logic [XC_W-1:0]   XC_ONE      = XC_W'(1);
    localparam logic [XC_W-1:0]   XC_FULL     = XC_W'(KK);
    localparam logic [XC_W-1:0]   XC_LASTRD   = XC_W'(KK - 1);
    localparam logic [FC_W-1:0]   FC_ZERO     = FC_W'(0);
    localparam logic [FC_W-1:0]   FC_ONE      = FC_W'(1);
    localparam logic [FC_W-1:0]   FC_FULL     = FC_W'(NKK);

    // Window origin and intra-window offsets
    logic [ADDR_W-1:0] r0_q, r0_d;
    logic [ADDR_W-1:0] c0_q, c0_d;
    logic [IJ_W-1:0]   i_q, i_d;
    logic [IJ_W-1:0]   j_q, j_d;
    // org_row = r0*IFM_W, cur_row = (r0+i)*IFM_W, both kept incrementally
    logic [ADDR_W-1:0] org_row_q, org_row_d;
    logic [ADDR_W-1:0] cur_row_q, cur_row_d;
    logic [XC_W-1:0]   xcnt_q, xcnt_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [ADDR_W-1:0] zptr_q, zptr_d;
    logic              first_win_q, first_win_d;
    logic [1:0]        last_sel_q, last_sel_d;
    logic              done_q, done_d;

    logic [1:0]        eff_sel_s;
    logic              x_step_s;
    logic              y_step_s;
    logic              at_last_s;
    logic [ADDR_W-1:0] x_adr_s;
    logic [ADDR_W-1:0] adr_s;

    // Effective source select and pointer-step qualifiers
    always_comb begin
        if (bus_io.sel == SEL_HOLD) begin
            eff_sel_s = last_sel_q;
        end else begin
            eff_sel_s = bus_io.sel;
        end
        x_step_s  = bus_io.reMem && (eff_sel_s == SEL_X) && (xcnt_q < XC_FULL);
        y_step_s  = bus_io.reMem && (eff_sel_s == SEL_Y) && (fcnt_q < FC_FULL);
        at_last_s = (r0_q == R0_LAST) && (c0_q == C0_LAST);
        x_adr_s   = IFM_BASE_A + cur_row_q + c0_q + ADDR_W'(j_q);
    end

    // Memory address mux, zero latency from sel
    always_comb begin
        adr_s = x_adr_s;
        case (eff_sel_s)
            SEL_X:   adr_s = x_adr_s;
            SEL_Y:   adr_s = FILT_BASE_A + ADDR_W'(fcnt_q);
            SEL_Z:   adr_s = zptr_q;
            default: adr_s = x_adr_s;
        endcase
    end

    // Next-state logic: ldAdr over rstX over pointer steps
    always_comb begin
        r0_d        = r0_q;
        c0_d        = c0_q;
        i_d         = i_q;
        j_d         = j_q;
        org_row_d   = org_row_q;
        cur_row_d   = cur_row_q;
        xcnt_d      = xcnt_q;
        fcnt_d      = fcnt_q;
        zptr_d      = zptr_q;
        first_win_d = first_win_q;
        last_sel_d  = last_sel_q;
        done_d      = done_q;

        if (bus_io.ldAdr) begin
            r0_d        = ADDR_ZERO;
            c0_d        = ADDR_ZERO;
            i_d         = IJ_ZERO;
            j_d         = IJ_ZERO;
            org_row_d   = ADDR_ZERO;
            cur_row_d   = ADDR_ZERO;
            xcnt_d      = XC_ZERO;
            fcnt_d      = FC_ZERO;
            zptr_d      = OFM_BASE_A;
            first_win_d = 1'b1;
            last_sel_d  = SEL_X;
            done_d      = 1'b0;
        end else begin
            if (bus_io.sel != SEL_HOLD) begin
                last_sel_d = bus_io.sel;
            end else begin
                last_sel_d = last_sel_q;
            end

            if (bus_io.rstX) begin
                i_d    = IJ_ZERO;
                j_d    = IJ_ZERO;
                xcnt_d = XC_ZERO;
                // The first rstX after a reload only arms the walk; origin stays
                if (first_win_q) begin
                    first_win_d = 1'b0;
                    cur_row_d   = org_row_q;
                end else if (c0_q < C0_LAST) begin
                    c0_d      = c0_q + ADDR_ONE;
                    cur_row_d = org_row_q;
                end else if (r0_q < R0_LAST) begin
                    c0_d      = ADDR_ZERO;
                    r0_d      = r0_q + ADDR_ONE;
                    org_row_d = org_row_q + ROW_STEP_A;
                    cur_row_d = org_row_q + ROW_STEP_A;
                end else begin
                    // Last window: origin stays put
                    cur_row_d = org_row_q;
                end
            end else if (x_step_s) begin
                xcnt_d = xcnt_q + XC_ONE;
                // The final read of a window leaves i/j on the last word
                if (xcnt_q == XC_LASTRD) begin
                    if (at_last_s) begin
                        done_d = 1'b1;
                    end else begin
                        done_d = done_q;
                    end
                end else if (j_q == IJ_LAST) begin
                    j_d       = IJ_ZERO;
                    i_d       = i_q + IJ_ONE;
                    cur_row_d = cur_row_q + ROW_STEP_A;
                end else begin
                    j_d = j_q + IJ_ONE;
                end
            end else begin
                xcnt_d = xcnt_q;
            end

            if (y_step_s) begin
                fcnt_d = fcnt_q + FC_ONE;
            end else begin
                fcnt_d = fcnt_q;
            end

            if (bus_io.weMem) begin
                zptr_d = zptr_q + ADDR_ONE;
            end else begin
                zptr_d = zptr_q;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r0_q        <= ADDR_ZERO;
            c0_q        <= ADDR_ZERO;
            i_q         <= IJ_ZERO;
            j_q         <= IJ_ZERO;
            org_row_q   <= ADDR_ZERO;
            cur_row_q   <= ADDR_ZERO;
            xcnt_q      <= XC_ZERO;
            fcnt_q      <= FC_ZERO;
            zptr_q      <= OFM_BASE_A;
            first_win_q <= 1'b1;
            last_sel_q  <= SEL_X;
            done_q      <= 1'b0;
        end else begin
            r0_q        <= r0_d;
            c0_q        <= c0_d;
            i_q         <= i_d;
            j_q         <= j_d;
            org_row_q   <= org_row_d;
            cur_row_q   <= cur_row_d;
            xcnt_q      <= xcnt_d;
            fcnt_q      <= fcnt_d;
            zptr_q      <= zptr_d;
            first_win_q <= first_win_d;
            last_sel_q  <= last_sel_d;
            done_q      <= done_d;
        end
    end

    assign bus_io.adr     = adr_s;
    assign bus_io.winDone = (xcnt_q == XC_FULL);
    assign bus_io.doneAdr = done_q;

endmodule

// File: tb/tb_address_generator.sv
// ---------------------------------------------------------------------------
// tb_address_generator
// Self-checking bench for address_generator: directed steps from the test
// plan followed by randomized traffic, all checked against a behavioural
// model that computes window addresses with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_address_generator;

    localparam int ADDR_W    = 16;
    localparam int IFM_BASE  = 0;
    localparam int FILT_BASE = 64;
    localparam int OFM_BASE  = 128;
    localparam int IFM_W     = 8;
    localparam int IFM_H     = 8;
    localparam int K         = 3;
    localparam int N         = 2;
    localparam int KK        = K * K;
    localparam int NKK       = N * KK;

    logic clk = 1'b0;
    logic rstN;

    address_generator_if #(.ADDR_W(ADDR_W)) bus ();

    address_generator #(
        .ADDR_W(ADDR_W), .IFM_BASE(IFM_BASE), .FILT_BASE(FILT_BASE),
        .OFM_BASE(OFM_BASE), .IFM_W(IFM_W), .IFM_H(IFM_H), .K(K), .N(N)
    ) dut (
        .clk    (clk),
        .rstN   (rstN),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_r0, m_c0, m_x, m_f, m_z, m_first, m_last, m_done;

    int n_vec = 0;
    int n_err = 0;
    logic [ADDR_W-1:0] obs_adr;
    logic              obs_win;
    logic              obs_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task model_reset();
        m_r0 = 0; m_c0 = 0; m_x = 0; m_f = 0;
        m_z = OFM_BASE; m_first = 1; m_last = 0; m_done = 0;
    endtask

    function automatic logic [31:0] model_adr(input logic [1:0] s);
        int eff, ii, jj, a;
        eff = (s == 2'b11) ? m_last : int'(s);
        if (m_x >= KK) begin
            ii = K - 1; jj = K - 1;
        end else begin
            ii = m_x / K; jj = m_x % K;
        end
        case (eff)
            1:       a = FILT_BASE + m_f;
            2:       a = m_z;
            default: a = IFM_BASE + (m_r0 + ii) * IFM_W + m_c0 + jj;
        endcase
        return 32'(a % 65536);
    endfunction

    task automatic model_step(input logic ld, input logic rx, input logic [1:0] s,
                              input logic re, input logic we);
        int eff;
        eff = (s == 2'b11) ? m_last : int'(s);
        if (ld) begin
            model_reset();
        end else begin
            if (s != 2'b11) m_last = int'(s);
            if (rx) begin
                m_x = 0;
                if (m_first != 0) m_first = 0;
                else if (m_c0 < IFM_W - K) m_c0++;
                else if (m_r0 < IFM_H - K) begin m_c0 = 0; m_r0++; end
            end else if (re && eff == 0 && m_x < KK) begin
                m_x++;
                if (m_x == KK && m_r0 == IFM_H - K && m_c0 == IFM_W - K) m_done = 1;
            end
            if (re && eff == 1 && m_f < NKK) m_f++;
            if (we) m_z = (m_z + 1) % 65536;
        end
    endtask

    // One clock: drive, check outputs against the model, then advance the model
    task automatic cycle(input logic ld, input logic rx, input logic [1:0] s,
                         input logic re, input logic we);
        @(negedge clk);
        bus.ldAdr = ld; bus.rstX = rx; bus.sel = s; bus.reMem = re; bus.weMem = we;
        #1;
        obs_adr  = bus.adr;
        obs_win  = bus.winDone;
        obs_done = bus.doneAdr;
        chk("adr",     32'(obs_adr),  model_adr(s));
        chk("winDone", 32'(obs_win),  32'(m_x == KK));
        chk("doneAdr", 32'(obs_done), 32'(m_done));
        @(posedge clk);
        model_step(ld, rx, s, re, we);
    endtask

    int win1 [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    initial begin
        logic [1:0] rs;
        rstN = 1'b0;
        bus.ldAdr = 1'b0; bus.rstX = 1'b0; bus.sel = 2'b11;
        bus.reMem = 1'b0; bus.weMem = 1'b0;
        model_reset();
        #1;
        chk("rst_adr",     32'(bus.adr),     32'd0);
        chk("rst_winDone", 32'(bus.winDone), 32'd0);
        chk("rst_doneAdr", 32'(bus.doneAdr), 32'd0);
        @(negedge clk);
        #2 rstN = 1'b1;

        // Filter load with saturation
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
            chk("filt_adr", 32'(obs_adr), 32'(64 + ((k < 18) ? k : 18)));
        end
        cycle(1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        chk("filt_sat", 32'(obs_adr), 32'd82);

        // First window
        cycle(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
            chk("win1_adr", 32'(obs_adr), 32'(win1[k]));
        end
        cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        chk("win1_hold", 32'(obs_adr), 32'd18);
        chk("win1_done", 32'(obs_win), 32'd1);

        // Window walk
        cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("walk_01", 32'(obs_adr), 32'd1);
        repeat (4) cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("walk_05", 32'(obs_adr), 32'd5);
        cycle(1'b0, 1'b1, 2'b00, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("walk_10", 32'(obs_adr), 32'd8);

        // Last window: from (1,0) to (5,5) is 29 steps
        repeat (29) cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
            if (k == 0) chk("last_first", 32'(obs_adr), 32'd45);
            if (k == 8) begin
                chk("last_adr",    32'(obs_adr),  32'd63);
                chk("last_early",  32'(obs_done), 32'd0);
            end
        end
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("last_done", 32'(obs_done), 32'd1);
        cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("last_hold",   32'(obs_adr),  32'd45);
        chk("last_sticky", 32'(obs_done), 32'd1);

        // Reset in the middle of a window read
        repeat (3) cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        @(negedge clk);
        bus.ldAdr = 1'b0; bus.rstX = 1'b0; bus.sel = 2'b00;
        bus.reMem = 1'b1; bus.weMem = 1'b0;
        #1 rstN = 1'b0;
        #1;
        chk("arst_adr",     32'(bus.adr),     32'd0);
        chk("arst_doneAdr", 32'(bus.doneAdr), 32'd0);
        chk("arst_winDone", 32'(bus.winDone), 32'd0);
        model_reset();
        bus.reMem = 1'b0;
        #1 rstN = 1'b1;

        // OFM write handshake
        cycle(1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        chk("ofm_sel", 32'(obs_adr), 32'd128);
        cycle(1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
        chk("ofm_wr", 32'(obs_adr), 32'd128);
        cycle(1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
        chk("ofm_next", 32'(obs_adr), 32'd129);

        // ldAdr colliding with a filter read
        repeat (5) cycle(1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        chk("ld_filt", 32'(obs_adr), 32'd64);
        cycle(1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        chk("ld_ofm", 32'(obs_adr), 32'd128);

        // Full randomized sweep over every window
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        repeat (37) begin
            cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));
            repeat (9 + $urandom_range(0, 4)) begin
                rs = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
                cycle(1'b0, 1'b0, rs, 1'($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 3) == 0));
            end
        end

        // Free-running random traffic
        repeat (600) begin
            cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 9) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
